// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and the hex-to-segment decoder for the seg_scan_driver block.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // How the display register is updated in a given cycle.
    typedef enum logic [1:0] {
        UPD_HOLD,
        UPD_PEND,
        UPD_BYPASS,
        UPD_COMMIT
    } upd_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] i_hex);
        return HEX_SEG[i_hex];
    endfunction

endpackage

// File: rtl/seg_scan_driver_prescaler.sv
// Slot prescaler and digit index counter for the scan driver.
// Produces the frame-boundary strobe (last cycle of the last digit slot).
module scan_prescaler #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    localparam int PW        = $clog2(SCAN_DIV),
    localparam int IW        = $clog2(NUM_DIGITS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic [PW-1:0] o_p,
    output logic [IW-1:0] o_idx,
    output logic          o_frame
);

    logic [PW-1:0] r_p;
    logic [IW-1:0] r_idx;
    logic          w_term;

    assign w_term  = (r_p == PW'(SCAN_DIV - 1));
    assign o_frame = w_term && (r_idx == IW'(NUM_DIGITS - 1));
    assign o_p     = r_p;
    assign o_idx   = r_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p   <= '0;
            r_idx <= '0;
        end else if (w_term) begin
            r_p <= '0;
            if (r_idx == IW'(NUM_DIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            r_p <= r_p + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver; new values take effect only at frame boundaries.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
import seg_pkg::*;

module seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*NUM_DIGITS-1:0]       value_i,
    input  logic [NUM_DIGITS-1:0]         dp_i,
    input  logic                          load_i,
    output logic [6:0]                    seg_o,
    output logic                          dp_o,
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
    output logic                          frame_done_o
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [PW-1:0]           w_p;
    logic [IW-1:0]           w_idx;
    logic                    w_frame;

    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [NUM_DIGITS-1:0]   r_dpr;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_valid;

    logic [6:0]              r_seg;
    logic                    r_dp_n;
    logic [NUM_DIGITS-1:0]   r_an;
    logic                    r_frame_done;

    upd_e                    w_upd;
    logic [3:0]              w_digit;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_an;

    scan_prescaler #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_prescaler (
        .i_clk   (clk),
        .i_rst   (rst),
        .o_p     (w_p),
        .o_idx   (w_idx),
        .o_frame (w_frame)
    );

    // A load in the boundary cycle wins over anything already pending.
    always_comb begin
        w_upd = UPD_HOLD;
        if (w_frame) begin
            if (load_i) begin
                w_upd = UPD_BYPASS;
            end else if (r_pend_valid) begin
                w_upd = UPD_COMMIT;
            end
        end else if (load_i) begin
            w_upd = UPD_PEND;
        end
    end

    always_comb begin
        w_digit = r_disp[4*w_idx +: 4];
        w_blank = 1'b0;
`ifdef SEG_LZB_EN
        w_blank = (w_idx != '0) && ((r_disp >> (4*w_idx)) == '0) && !r_dpr[w_idx];
`endif
        w_an = '1;
        if (w_p >= PW'(BLANK_CYC)) begin
            w_an[w_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp       <= '0;
            r_dpr        <= '0;
            r_pend       <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
            r_seg        <= SEG_OFF;
            r_dp_n       <= 1'b1;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_blank ? SEG_OFF : hex_to_seg(w_digit);
            r_dp_n       <= w_blank | ~r_dpr[w_idx];
            r_an         <= w_an;
            r_frame_done <= w_frame;
            case (w_upd)
                UPD_PEND: begin
                    r_pend       <= value_i;
                    r_pend_dp    <= dp_i;
                    r_pend_valid <= 1'b1;
                end
                UPD_BYPASS: begin
                    r_disp       <= value_i;
                    r_dpr        <= dp_i;
                    r_pend_valid <= 1'b0;
                end
                UPD_COMMIT: begin
                    r_disp       <= r_pend;
                    r_dpr        <= r_pend_dp;
                    r_pend_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign seg_o        = r_seg;
    assign dp_o         = r_dp_n;
    assign an_o         = r_an;
    assign frame_done_o = r_frame_done;
    assign digit_idx_o  = w_idx;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized self-checking bench for seg_scan_driver against a cycle-count based model.
// Honours SEG_LZB_EN the same way as the design build.
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int BC = 1;
    localparam int FRAME = N * SD;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_i;
    logic [3:0]  dp_i;
    logic        load_i;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [3:0]  an_o;
    logic [1:0]  digit_idx_o;
    logic        frame_done_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: cycles since reset plus the displayed/pending data.
    int          m_t;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_dpr, m_pend_dp;
    logic        m_pv;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .BLANK_CYC  (BC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .value_i      (value_i),
        .dp_i         (dp_i),
        .load_i       (load_i),
        .seg_o        (seg_o),
        .dp_o         (dp_o),
        .an_o         (an_o),
        .digit_idx_o  (digit_idx_o),
        .frame_done_o (frame_done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, predict the post-edge outputs, advance the model, compare.
    task automatic tick(input logic rs, input logic ld, input logic [15:0] v, input logic [3:0] d);
        int         p, ix, e_idx;
        logic       bnd, e_dp, e_fd;
        logic [3:0] dg, e_an;
        logic [6:0] e_seg;
        rst = rs; load_i = ld; value_i = v; dp_i = d;
        if (rs) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0; e_idx = 0;
            m_t = 0; m_disp = '0; m_dpr = '0; m_pv = 1'b0;
        end else begin
            p   = m_t % SD;
            ix  = (m_t / SD) % N;
            bnd = (m_t % FRAME) == FRAME - 1;
            dg  = 4'(m_disp >> (4 * ix));
            e_seg = SEG_TBL[dg];
            e_dp  = ~m_dpr[ix];
`ifdef SEG_LZB_EN
            if (ix > 0 && (m_disp >> (4 * ix)) == 16'h0 && !m_dpr[ix]) begin
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end
`endif
            e_an = 4'hF;
            if (p >= BC) e_an[ix] = 1'b0;
            e_fd = bnd;
            if (bnd && ld) begin
                m_disp = v; m_dpr = d; m_pv = 1'b0;
            end else if (bnd && m_pv) begin
                m_disp = m_pend; m_dpr = m_pend_dp; m_pv = 1'b0;
            end else if (ld) begin
                m_pend = v; m_pend_dp = d; m_pv = 1'b1;
            end
            m_t++;
            e_idx = (m_t / SD) % N;
        end
        @(posedge clk);
        #1;
        chk("seg", 32'(seg_o), 32'(e_seg));
        chk("dp", 32'(dp_o), 32'(e_dp));
        chk("an", 32'(an_o), 32'(e_an));
        chk("idx", 32'(digit_idx_o), 32'(e_idx));
        chk("frame_done", 32'(frame_done_o), 32'(e_fd));
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    // Advance until the next cycle to be driven sits at the given frame phase.
    task automatic run_to(input int phase);
        for (int k = 0; k < FRAME && (m_t % FRAME) != phase; k++) idle();
    endtask

    initial begin
        int first_fd, cnt_a, cnt_b, cnt_c, r;
        rst = 1'b1; load_i = 1'b0; value_i = '0; dp_i = '0;
        m_t = 0; m_disp = '0; m_pend = '0; m_dpr = '0; m_pend_dp = '0; m_pv = 1'b0;

        repeat (3) tick(1'b1, 1'b0, 16'h0, 4'h0);

        first_fd = -1;
        for (int i = 1; i <= 40; i++) begin
            idle();
            if (frame_done_o === 1'b1 && first_fd < 0) first_fd = i;
        end
        chk("first_frame_done", 32'(first_fd), 32'd16);

        // Mid-frame load appears only after the boundary.
        run_to(5);
        tick(1'b0, 1'b1, 16'h00B1, 4'h0);
        run_to(15);
        idle();
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < FRAME; i++) begin
            idle();
            if (an_o == 4'b1101 && seg_o == 7'b0000011) cnt_a++;
            if (an_o == 4'b1110 && seg_o == 7'b1111001) cnt_b++;
        end
        chk("b1_digit1_slots", 32'(cnt_a), 32'd3);
        chk("b1_digit0_slots", 32'(cnt_b), 32'd3);

        // Two loads in one frame: last wins.
        run_to(2);
        tick(1'b0, 1'b1, 16'h1234, 4'h0);
        run_to(9);
        tick(1'b0, 1'b1, 16'h5678, 4'h0);
        run_to(15);
        idle();
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < FRAME; i++) begin
            idle();
            if (an_o == 4'b0111 && seg_o == 7'b1111001) cnt_a++;
            if (an_o == 4'b0111 && seg_o == 7'b0010010) cnt_b++;
        end
        chk("stale_1234_seen", 32'(cnt_a), 32'd0);
        chk("last_load_5678", 32'(cnt_b), 32'd3);

        // Load in the boundary cycle bypasses and discards pending.
        run_to(3);
        tick(1'b0, 1'b1, 16'h1111, 4'h0);
        run_to(15);
        tick(1'b0, 1'b1, 16'hC0DE, 4'h0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < FRAME; i++) begin
            idle();
            if (an_o == 4'b0111 && seg_o == 7'b1000110) cnt_a++;
            if (an_o == 4'b1110 && seg_o == 7'b1111001) cnt_b++;
        end
        chk("bypass_c0de", 32'(cnt_a), 32'd3);
        chk("pending_1111_seen", 32'(cnt_b), 32'd0);

        // Reset mid-frame with data pending.
        run_to(2);
        tick(1'b0, 1'b1, 16'h9999, 4'hF);
        run_to(8);
        tick(1'b1, 1'b0, 16'h0, 4'h0);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (seg_o == 7'b0010000) cnt_a++;
            if (dp_o == 1'b0) cnt_b++;
        end
        chk("pending_after_reset", 32'(cnt_a), 32'd0);
        chk("dp_after_reset", 32'(cnt_b), 32'd0);

        // Leading zeros with a lit decimal point on digit 2.
        run_to(4);
        tick(1'b0, 1'b1, 16'h000B, 4'b0100);
        run_to(15);
        idle();
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < FRAME; i++) begin
            idle();
            if (an_o == 4'b1011 && seg_o == 7'b1000000 && dp_o == 1'b0) cnt_a++;
`ifdef SEG_LZB_EN
            if (an_o == 4'b0111 && seg_o == 7'h7F) cnt_b++;
`else
            if (an_o == 4'b0111 && seg_o == 7'b1000000) cnt_b++;
`endif
            if (an_o == 4'b1110 && seg_o == 7'b0000011) cnt_c++;
        end
        chk("lz_digit2_dp", 32'(cnt_a), 32'd3);
        chk("lz_digit3", 32'(cnt_b), 32'd3);
        chk("lz_digit0", 32'(cnt_c), 32'd3);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                tick(1'b1, 1'b0, 16'($urandom), 4'($urandom));
            end else if (r < 30) begin
                tick(1'b0, 1'b1, 16'($urandom), 4'($urandom));
            end else begin
                idle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
